// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer
//   Read sequencer in front of the SRAM wrapper. A burst command (start row,
//   row count) turns into one rd_req per row; returned rows are buffered in
//   a small FIFO and streamed out on a valid/ready interface. Requests are
//   only issued while FIFO space (entries + the one read in flight) is
//   available, so backpressure never drops or overwrites a row.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   burst command handshake (ready only while idle)
//   cmd_addr, cmd_len     first row, number of rows (0 = empty burst)
//   mem_en, rd_req        wrapper enable / read request (one row per cycle)
//   wr_req                always 0, writes are owned elsewhere
//   address               wrapper row address
//   rd_data_val, rd_data  wrapper read return, one cycle after rd_req
//   out_valid/out_ready   row stream handshake
//   out_data, out_last    row data, final-row marker
//   busy, done            burst in progress, one-cycle completion pulse
//
// Optional build macro SRAM_RD_STREAMER_CHK_EN adds a sticky proto_err
// output flagging unexpected read returns and pushes into a full FIFO.

module sram_rd_streamer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 7,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_en,
  output logic              rd_req,
  output logic              wr_req,
  output logic [ADDR_W-1:0] address,
  input  logic              rd_data_val,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
`ifdef SRAM_RD_STREAMER_CHK_EN
  output logic              proto_err,
`endif
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;
  logic                armed_q, armed_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic cmd_accept, credit_ok, issue, push, pop, head_last;

  always_comb begin
    cmd_accept = cmd_valid && (state_q == IDLE);
    // Count the read in flight as already occupying an entry so its return
    // always finds room.
    credit_ok  = ({1'b0, count_q} + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
    issue      = (state_q == ISSUE) && credit_ok;
    // A return on the first cycle out of reset belongs to a discarded read.
    push       = rd_data_val && armed_q;
    pop        = (count_q != '0) && out_ready;
    head_last  = fifo_last_q[rd_ptr_q];

    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == LEN_W'(1));
    armed_d         = 1'b1;
    done_d          = (cmd_accept && (cmd_len == '0)) || (pop && head_last);
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_accept && (cmd_len != '0)) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last-flagged row is the final push, so popping it empties the FIFO.
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = rd_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      armed_q         <= 1'b0;
      done_q          <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      armed_q         <= armed_d;
      done_q          <= done_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

`ifdef SRAM_RD_STREAMER_CHK_EN
  logic proto_err_q, proto_err_d;

  always_comb begin
    proto_err_d = proto_err_q
                || (armed_q && rd_data_val && !inflight_q)
                || (push && (count_q == CNT_W'(FIFO_DEPTH)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) proto_err_q <= 1'b0;
    else        proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign rd_req    = issue;
  assign mem_en    = issue;
  assign wr_req    = 1'b0;
  assign address   = addr_q;
  assign out_valid = (count_q != '0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  // Popped slots keep their stale last bit, so qualify with valid.
  assign out_last  = out_valid && head_last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sram_rd_streamer.sv
module tb_sram_rd_streamer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              mem_en, rd_req, wr_req;
  logic [ADDR_W-1:0] address;
  logic              rd_data_val;
  logic [DATA_W-1:0] rd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last, busy, done;
`ifdef SRAM_RD_STREAMER_CHK_EN
  logic              proto_err;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_rd_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_en(mem_en), .rd_req(rd_req),
    .wr_req(wr_req), .address(address), .rd_data_val(rd_data_val), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy),
`ifdef SRAM_RD_STREAMER_CHK_EN
    .proto_err(proto_err),
`endif
    .done(done)
  );

  // SRAM model: registered read, data valid one cycle after rd_req.
  logic [DATA_W-1:0] sram [128];
  logic sram_v = 1'b0;
  logic inject = 1'b0;
  assign rd_data_val = sram_v | inject;
  always @(posedge clk) begin
    sram_v <= rd_req;
    if (rd_req) rd_data <= sram[address];
  end

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else n_pass++;
    n_chk++; if ({mem_en, rd_req, wr_req} !== 3'b000) $display("FAIL reset_mem got %b want 000", {mem_en, rd_req, wr_req}); else n_pass++;
    n_chk++; if (address !== '0) $display("FAIL reset_address got %h want 00", address); else n_pass++;
    n_chk++; if ({out_valid, out_last, busy, done} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {out_valid, out_last, busy, done}); else n_pass++;
    n_chk++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
  endtask

  // mode 0: consumer always ready; 1: random ready; 2: stalled for 8 cycles then ready
  task automatic run_burst(input logic [ADDR_W-1:0] a, input int l, input int mode, input string tag);
    int issued = 0, rcv = 0, done_cnt = 0, last_hs = 0, stall_req = 0, first_v = -1, fin_k = -1;
    bit fin = 0, prev_stall = 0, prev_last = 0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [ADDR_W-1:0] idx;
    @(negedge clk);
    n_chk++; if (cmd_ready !== 1'b1) $display("FAIL %s_cmd_ready_idle got %b want 1", tag, cmd_ready); else n_pass++;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = LEN_W'(l);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 400 && !fin; k++) begin
      if (k == 1) begin
        n_chk++; if (busy !== (l != 0)) $display("FAIL %s_busy got %b want %b", tag, busy, (l != 0)); else n_pass++;
      end
      // Commands while not idle must be ignored.
      if (k == 2 && l > 0) begin
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL %s_cmd_ready_busy got %b want 0", tag, cmd_ready); else n_pass++;
        cmd_valid = 1'b1; cmd_addr = 7'h55; cmd_len = 8'd5;
      end
      if (k == 3) cmd_valid = 1'b0;
      if (rd_req) begin
        idx = a + ADDR_W'(issued);
        n_chk++; if (address !== idx || mem_en !== 1'b1 || wr_req !== 1'b0)
          $display("FAIL %s_req_addr got %h want %h (mem_en %b wr_req %b)", tag, address, idx, mem_en, wr_req); else n_pass++;
        issued++;
        if (mode == 2 && k <= 8) stall_req++;
      end
      if (out_valid && first_v < 0) begin
        first_v = k;
        n_chk++; if (k != 3) $display("FAIL %s_latency got %0d want 3", tag, k); else n_pass++;
      end
      if (prev_stall) begin
        n_chk++; if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last)
          $display("FAIL %s_stall_hold got %b/%h/%b want 1/%h/%b", tag, out_valid, out_data, out_last, prev_data, prev_last); else n_pass++;
      end
      if (done) begin
        done_cnt++; fin_k = k;
        n_chk++; if (k != last_hs + 1) $display("FAIL %s_done_time got %0d want %0d", tag, k, last_hs + 1); else n_pass++;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (k > 8);
      endcase
      if (out_valid && out_ready) begin
        idx = a + ADDR_W'(rcv);
        n_chk++; if (rcv >= l || out_data !== sram[idx] || out_last !== (rcv == l - 1))
          $display("FAIL %s_beat%0d got %h/%b want %h/%b", tag, rcv, out_data, out_last, sram[idx], (rcv == l - 1)); else n_pass++;
        rcv++; last_hs = k;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_last = out_last;
      if (done_cnt > 0 && k == fin_k + 2) fin = 1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_chk++; if (!fin) $display("FAIL %s_timeout got no done want done", tag); else n_pass++;
    n_chk++; if (issued != l || rcv != l) $display("FAIL %s_counts got req %0d beats %0d want %0d", tag, issued, rcv, l); else n_pass++;
    n_chk++; if (done_cnt != 1) $display("FAIL %s_done_pulses got %0d want 1", tag, done_cnt); else n_pass++;
    n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL %s_end_idle got %b/%b want 1/0", tag, cmd_ready, busy); else n_pass++;
    if (mode == 2) begin
      n_chk++; if (stall_req > DEPTH) $display("FAIL %s_stall_reqs got %0d want <= %0d", tag, stall_req, DEPTH); else n_pass++;
    end
  endtask

  task automatic test_basic();        run_burst(7'h10, 4, 0, "basic"); endtask
  task automatic test_backpressure(); run_burst(7'($urandom_range(0, 127)), 10, 2, "bp"); endtask
  task automatic test_wrap();         run_burst(7'h7E, 4, 0, "wrap"); endtask
  task automatic test_zero_len();     run_burst(7'h33, 0, 0, "zero"); endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_burst(7'($urandom_range(0, 127)), int'($urandom_range(1, 20)), 1, "rand");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_burst(7'($urandom_range(0, 127)), int'($urandom_range(1, 6)), 0, "b2b");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 7'h40; cmd_len = 8'd8;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if ({cmd_ready, mem_en, rd_req, wr_req, out_valid, out_last, busy, done} !== 8'b1000_0000)
      $display("FAIL midrst_flags got %b want 10000000", {cmd_ready, mem_en, rd_req, wr_req, out_valid, out_last, busy, done}); else n_pass++;
    n_chk++; if (address !== '0 || out_data !== '0) $display("FAIL midrst_data got %h/%h want 00/0", address, out_data); else n_pass++;
    rst_n = 1'b1; inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL midrst_ignore got %b want 0", out_valid); else n_pass++;
    run_burst(7'h20, 2, 0, "postrst");
  endtask

`ifdef SRAM_RD_STREAMER_CHK_EN
  task automatic test_checker();
    @(negedge clk);
    n_chk++; if (proto_err !== 1'b0) $display("FAIL chk_clean got %b want 0", proto_err); else n_pass++;
    inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    @(negedge clk);
    n_chk++; if (proto_err !== 1'b1) $display("FAIL chk_set got %b want 1", proto_err); else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++; if (proto_err !== 1'b1) $display("FAIL chk_sticky got %b want 1", proto_err); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (proto_err !== 1'b0) $display("FAIL chk_reset got %b want 0", proto_err); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) sram[i] = $urandom;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef SRAM_RD_STREAMER_CHK_EN
    test_checker();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
